perceptron_train_ctrl: RTL and testbench
========================================

Name: perceptron_train_ctrl

Overview:
Moore FSM controller that sequences the perceptron training datapath: weight/bias registers, sample registers, net-output register and sample-memory address.
- Clears the weights, then steps through every training sample each epoch. For each sample it loads the sample, computes the output, checks it against the target and updates the weights on a mismatch.
- Stops when an epoch has no errors (converged) or when the epoch limit is reached.
- Sits between the top-level start/done interface and the register load/clear strobes of the datapath.

Parameters:
N_SAMPLES, 100, training samples per epoch (>=1)
ADDR_W, 7, sample address width; 2**ADDR_W >= N_SAMPLES
MAX_EPOCHS, 15, epoch limit (>=1)
EPOCH_W, 4, epoch counter width; 2**EPOCH_W > MAX_EPOCHS

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin/restart training; sampled only in IDLE or DONE
mismatch  in  1  datapath: registered output != target; sampled only in CHECK
init0_w  out  1  clear weight and bias registers (drives their init0)
ld_x  out  1  load sample/target registers from memory at addr
ld_y  out  1  load net-output/sign register
ld_w  out  1  load updated weights and bias
addr  out  ADDR_W  sample memory address
epoch  out  EPOCH_W  epochs completed
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE
converged  out  1  valid while done=1; 1 = last epoch had zero errors

Behaviour:
- Reset (async, any state, including mid-epoch): state=IDLE, addr=0, epoch=0, err_flag=0, converged=0. All strobes, busy and done are 0.
- Strobes are a combinational decode of the state only, so they are glitch-free relative to clk. At most one of init0_w/ld_x/ld_y/ld_w is high in any cycle.
- IDLE: start=1 -> INIT, otherwise stay.
- INIT (1 cycle):
  - init0_w=1.
  - On exit: addr<=0, epoch<=0, err_flag<=0, converged<=0.
  - Next state: LOAD.
- LOAD (1 cycle): ld_x=1. Memory read is combinational on addr. -> CALC.
- CALC (1 cycle): ld_y=1. -> CHECK.
- CHECK (1 cycle): no strobe. mismatch=1 -> UPDATE; mismatch=0 -> NEXT.
- UPDATE (1 cycle): ld_w=1, err_flag<=1. -> NEXT.
- NEXT (1 cycle):
  - addr==N_SAMPLES-1 -> EPOCH_END, addr unchanged.
  - Otherwise addr<=addr+1 -> LOAD.
  - addr never exceeds N_SAMPLES-1.
- EPOCH_END (1 cycle): epoch<=epoch+1, then:
  - err_flag==0: converged<=1 -> DONE.
  - Else if epoch+1==MAX_EPOCHS: converged<=0 -> DONE.
  - Else: addr<=0, err_flag<=0 -> LOAD.
- DONE:
  - done=1; epoch and converged are held.
  - start=1 -> INIT (full restart, weights cleared).
  - Otherwise stay.
- Timing:
  - 4 cycles per sample without an update, 5 with an update.
  - Plus 1 EPOCH_END cycle per epoch.
  - Plus 1 INIT cycle per run.
- start outside IDLE/DONE is ignored. mismatch outside CHECK is ignored.
- N_SAMPLES=1 boundary: NEXT goes straight to EPOCH_END every epoch.

Decomposition:
- Shared package perceptron_pkg holds:
  - state enum: IDLE, INIT, LOAD, CALC, CHECK, UPDATE, NEXT, EPOCH_END, DONE, 4-bit encoding;
  - default constants N_SAMPLES, MAX_EPOCHS.
- One natural sub-module: perceptron_counter, a generic up-counter with clr, inc and async rst. It is instantiated twice, for addr and for epoch.
- The FSM stays in perceptron_train_ctrl.

Test Plan:
Bench parameters N_SAMPLES=4, MAX_EPOCHS=3. E0 = the edge that samples start in IDLE.
- No mismatches: pulse start -> init0_w high E0..E1. ld_x high at addr 0,1,2,3 with 4-cycle spacing. ld_w never high. done=1 from E18, converged=1, epoch=1.
- Mismatch on sample 2 of epoch 1 only -> exactly one ld_w, in the cycle after CHECK of addr=2. Epoch 2 is clean. done at E0+36, converged=1, epoch=2.
- mismatch held high constantly -> 12 ld_w pulses. done with converged=0, epoch=3. addr=3 at done.
- rst asserted during CALC of epoch 2 -> immediately state=IDLE, addr=0, epoch=0, all outputs 0. A later start re-runs from INIT.
- start pulsed while busy (in LOAD) -> no effect, sequence unchanged. start in DONE -> init0_w next cycle, done drops, epoch=0.
- Toggle mismatch every cycle -> only the value during CHECK matters. Check ld_w pattern against the CHECK-cycle samples, and that no two strobes are ever high together.

Source files
------------

// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared definitions for the perceptron training controller:
//   - state_t      : controller state encoding (4 bits)
//   - ctrl_t       : bundle of datapath strobes and status flags
//   - decode_state : maps a state to its Moore outputs
//   - DEF_N_SAMPLES / DEF_MAX_EPOCHS : default training-run dimensions
// -----------------------------------------------------------------------------
package perceptron_pkg;

  localparam int DEF_N_SAMPLES  = 100;
  localparam int DEF_MAX_EPOCHS = 15;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    LOAD      = 4'd2,
    CALC      = 4'd3,
    CHECK     = 4'd4,
    UPDATE    = 4'd5,
    NEXT      = 4'd6,
    EPOCH_END = 4'd7,
    DONE      = 4'd8
  } state_t;

  typedef struct packed {
    logic init0_w;
    logic ld_x;
    logic ld_y;
    logic ld_w;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore output decode: each state raises at most one datapath strobe.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE:      c.busy = 1'b0;
      INIT:      begin c.init0_w = 1'b1; c.busy = 1'b1; end
      LOAD:      begin c.ld_x    = 1'b1; c.busy = 1'b1; end
      CALC:      begin c.ld_y    = 1'b1; c.busy = 1'b1; end
      CHECK:     c.busy = 1'b1;
      UPDATE:    begin c.ld_w    = 1'b1; c.busy = 1'b1; end
      NEXT:      c.busy = 1'b1;
      EPOCH_END: c.busy = 1'b1;
      DONE:      c.done = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/perceptron_counter.sv
// -----------------------------------------------------------------------------
// perceptron_counter
// Generic up-counter with synchronous clear (priority over increment).
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset (count -> 0)
//   clr   in  synchronous clear
//   inc   in  increment by one
//   count out current count (W bits)
// -----------------------------------------------------------------------------
module perceptron_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// -----------------------------------------------------------------------------
// perceptron_train_ctrl
// Moore FSM sequencing the perceptron training datapath. Clears the weights,
// then for every sample of every epoch: load sample, compute output, check
// against target, update weights on mismatch. Stops on an error-free epoch
// (converged=1) or when MAX_EPOCHS epochs have completed (converged=0).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin/restart training (honoured only in IDLE or DONE)
//   mismatch        datapath output != target (honoured only in CHECK)
//   init0_w         clear weight/bias registers
//   ld_x            load sample/target registers from memory at addr
//   ld_y            load net-output/sign register
//   ld_w            load updated weights and bias
//   addr            sample memory address
//   epoch           epochs completed
//   busy            training in progress (not IDLE, not DONE)
//   done            high while in DONE
//   converged       valid while done=1; last epoch had zero errors
// -----------------------------------------------------------------------------
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int ADDR_W     = 7,
  parameter int MAX_EPOCHS = DEF_MAX_EPOCHS,
  parameter int EPOCH_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mismatch,
  output logic               init0_w,
  output logic               ld_x,
  output logic               ld_y,
  output logic               ld_w,
  output logic [ADDR_W-1:0]  addr,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic               done,
  output logic               converged
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCHS - 1);

  state_t state;
  state_t next_state;
  logic   err_flag;
  logic   addr_clr;
  logic   addr_inc;
  logic   epoch_clr;
  logic   epoch_inc;

  perceptron_counter #(.W(ADDR_W)) u_addr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (addr_clr),
    .inc   (addr_inc),
    .count (addr)
  );

  perceptron_counter #(.W(EPOCH_W)) u_epoch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (epoch_clr),
    .inc   (epoch_inc),
    .count (epoch)
  );

  // Next-state and counter-control decode.
  // Counters are cleared both when a start is accepted and when INIT exits,
  // so addr/epoch already read 0 during the INIT cycle of a restart.
  always_comb begin
    next_state = state;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    epoch_clr  = 1'b0;
    epoch_inc  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = INIT;
          addr_clr   = 1'b1;
          epoch_clr  = 1'b1;
        end else begin
          next_state = state;
        end
      end
      INIT: begin
        next_state = LOAD;
        addr_clr   = 1'b1;
        epoch_clr  = 1'b1;
      end
      LOAD:   next_state = CALC;
      CALC:   next_state = CHECK;
      CHECK: begin
        if (mismatch) begin
          next_state = UPDATE;
        end else begin
          next_state = NEXT;
        end
      end
      UPDATE: next_state = NEXT;
      NEXT: begin
        if (addr == LAST_ADDR) begin
          next_state = EPOCH_END;
        end else begin
          next_state = LOAD;
          addr_inc   = 1'b1;
        end
      end
      EPOCH_END: begin
        epoch_inc = 1'b1;
        if (!err_flag || (epoch == LAST_EPOCH)) begin
          next_state = DONE;
        end else begin
          next_state = LOAD;
          addr_clr   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, epoch error/convergence flags and registered Moore outputs.
  // Outputs are registered from the decode of next_state, so they always equal
  // decode_state(state) without any combinational path after the flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      err_flag  <= 1'b0;
      converged <= 1'b0;
      {init0_w, ld_x, ld_y, ld_w, busy, done} <= '0;
    end else begin
      state <= next_state;
      {init0_w, ld_x, ld_y, ld_w, busy, done} <= decode_state(next_state);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_flag  <= 1'b0;
            converged <= 1'b0;
          end else begin
            err_flag  <= err_flag;
            converged <= converged;
          end
        end
        INIT: begin
          err_flag  <= 1'b0;
          converged <= 1'b0;
        end
        UPDATE: err_flag <= 1'b1;
        EPOCH_END: begin
          if (!err_flag) begin
            converged <= 1'b1;
          end else if (epoch == LAST_EPOCH) begin
            converged <= 1'b0;
          end else begin
            err_flag <= 1'b0;
          end
        end
        default: begin
          err_flag  <= err_flag;
          converged <= converged;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// -----------------------------------------------------------------------------
// tb_perceptron_train_ctrl
// Self-checking bench for perceptron_train_ctrl with N_SAMPLES=4, MAX_EPOCHS=3.
// Cycle k counts rising edges after E0 (the edge that samples start).
// -----------------------------------------------------------------------------
module tb_perceptron_train_ctrl;

  localparam int NS = 4;
  localparam int AW = 2;
  localparam int ME = 3;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mismatch;
  logic          init0_w;
  logic          ld_x;
  logic          ld_y;
  logic          ld_w;
  logic [AW-1:0] addr;
  logic [EW-1:0] epoch;
  logic          busy;
  logic          done;
  logic          converged;

  perceptron_train_ctrl #(
    .N_SAMPLES (NS),
    .ADDR_W    (AW),
    .MAX_EPOCHS(ME),
    .EPOCH_W   (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mismatch (mismatch),
    .init0_w  (init0_w),
    .ld_x     (ld_x),
    .ld_y     (ld_y),
    .ld_w     (ld_w),
    .addr     (addr),
    .epoch    (epoch),
    .busy     (busy),
    .done     (done),
    .converged(converged)
  );

  always #5 clk = ~clk;

  // mode: 0 no mismatch, 1 mismatch at CHECK of sample 2 epoch 1, 2 always, 3 toggle
  typedef struct {
    int mode;
    int start_k;
    int done_k;
    int conv;
    int ep;
    int addr_f;
    int nw;
  } vec_t;

  vec_t vecs[5];
  vec_t exp_q[$];
  bit   ldw_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_init0_w"}, init0_w, 0);
    chk({tag, "_ld_x"}, ld_x, 0);
    chk({tag, "_ld_y"}, ld_y, 0);
    chk({tag, "_ld_w"}, ld_w, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_epoch"}, epoch, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_converged"}, converged, 0);
  endtask

  function automatic logic mm_for(input int mode, input int k);
    case (mode)
      1:       return (k == 11);
      2:       return 1'b1;
      3:       return k[0];
      default: return 1'b0;
    endcase
  endfunction

  // Run one training pass from IDLE/DONE; abort_k >= 0 stops at that cycle.
  task automatic run_vec(input vec_t v, input int abort_k);
    int   k;
    int   nw;
    int   nx;
    bit   prev_ly;
    bit   exp_w;
    bit   seen_done;
    vec_t e;
    k = 0; nw = 0; nx = 0; prev_ly = 1'b0; seen_done = 1'b0;
    exp_q.push_back(v);
    ldw_q.delete();
    @(posedge clk); #1 start = 1'b1; mismatch = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    mismatch = mm_for(v.mode, 0);
    while (k < 200) begin
      @(negedge clk);
      chk("onehot", $countones({init0_w, ld_x, ld_y, ld_w}) <= 1, 1);
      chk("init0_w", init0_w, (k == 0));
      exp_w = (ldw_q.size() > 0) ? ldw_q.pop_front() : 1'b0;
      chk("ld_w", ld_w, exp_w);
      // Cycle after ld_y is CHECK; the mismatch seen now decides ld_w next cycle.
      ldw_q.push_back(prev_ly && mismatch);
      prev_ly = ld_y;
      if (ld_w) nw++;
      if (v.mode == 0 && ld_x) begin
        chk("ld_x_k", k, 1 + 4 * nx);
        chk("ld_x_addr", addr, nx);
        nx++;
      end
      if (k == abort_k) begin
        e = exp_q.pop_front();
        return;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      chk("busy_run", busy, 1);
      @(posedge clk); #1;
      k++;
      mismatch = mm_for(v.mode, k);
      start = (k == v.start_k);
    end
    e = exp_q.pop_front();
    chk("done_seen", seen_done, 1);
    chk("done_k", k, e.done_k);
    chk("converged", converged, e.conv);
    chk("epoch", epoch, e.ep);
    chk("addr_at_done", addr, e.addr_f);
    chk("ld_w_count", nw, e.nw);
    chk("busy_done", busy, 0);
    mismatch = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, -1, 18, 1, 1, 3, 0};
    vecs[1] = '{0,  5, 18, 1, 1, 3, 0};
    vecs[2] = '{1, -1, 36, 1, 2, 3, 1};
    vecs[3] = '{2, -1, 64, 0, 3, 3, 12};
    vecs[4] = '{3, -1, 55, 0, 3, 3, 3};

    rst = 1'b1; start = 1'b0; mismatch = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], -1);
    end

    // start while in DONE: restart with weights cleared next cycle
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("restart_init0_w", init0_w, 1);
    chk("restart_done", done, 0);
    chk("restart_epoch", epoch, 0);
    chk("restart_busy", busy, 1);

    // async reset mid-run, then rerun a mismatch-pass up to CALC of epoch 2
    #2 rst = 1'b1;
    #1 check_zero("rst_init");
    @(posedge clk); #1 rst = 1'b0;
    run_vec(vecs[2], 20);
    chk("calc_ep2_ld_y", ld_y, 1);
    chk("calc_ep2_epoch", epoch, 1);
    #2 rst = 1'b1;
    #1 check_zero("rst_calc");
    @(posedge clk); #1 rst = 1'b0;
    run_vec(vecs[0], -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
